// File: rtl/arm_imm_encoder.sv
// arm_imm_encoder: iterative search for the ARM data-processing immediate
// form {rotate_imm[3:0], immed_8[7:0]} of a 32-bit constant. One rotation
// is tried per clock. The smallest rotate_imm that fits is reported.
//
// Handshake: start is a request pulse that is sampled only in IDLE. busy is
// high from the accepted start until done. done is a one-cycle pulse. valid,
// shift_operand and inv are held from done until the next accepted start
// finishes.
//
// Optional feature macro: ARM_IMM_ENC_INV_EN. When it is defined and the
// plain search fails, a second pass searches ~value (MVN form) and flags a
// fit with inv=1. When it is undefined, inv is always 0.
module arm_imm_encoder #(
  parameter int MAX_ROT = 15,
  parameter int W       = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] value,
  output logic         busy,
  output logic         done,
  output logic         valid,
  output logic [11:0]  shift_operand,
  output logic         inv,
  output logic [1:0]   dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t         state_q;
  logic [W-1:0]   work_q;
  logic [3:0]     r_q;
  logic           busy_q;
  logic           done_q;
  logic           valid_q;
  logic [11:0]    so_q;
  logic           inv_q;
`ifdef ARM_IMM_ENC_INV_EN
  logic [W-1:0]   val_q;   // latched constant, reused for the inverted pass
  logic           pass_q;  // 0: plain search, 1: searching ~value
`endif

  logic [W-1:0]   work_rot_d;
  logic           fit_d;
  logic           last_rot_d;

  // The candidate fits when every bit above immed_8 is clear; the next
  // candidate is the work word rotated left by 2, with wraparound.
  always_comb begin
    work_rot_d = {work_q[W-3:0], work_q[W-1:W-2]};
    fit_d      = (work_q[W-1:8] == '0);
    last_rot_d = (r_q == 4'(MAX_ROT));
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      r_q     <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      so_q    <= 12'h000;
      inv_q   <= 1'b0;
`ifdef ARM_IMM_ENC_INV_EN
      val_q   <= '0;
      pass_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            work_q  <= value;
            r_q     <= 4'd0;
            busy_q  <= 1'b1;
            state_q <= SEARCH;
`ifdef ARM_IMM_ENC_INV_EN
            val_q   <= value;
            pass_q  <= 1'b0;
`endif
          end
        end
        SEARCH: begin
          if (fit_d) begin
            so_q    <= {r_q, work_q[7:0]};
            valid_q <= 1'b1;
`ifdef ARM_IMM_ENC_INV_EN
            inv_q   <= pass_q;
`else
            inv_q   <= 1'b0;
`endif
            state_q <= DONE;
          end else if (last_rot_d) begin
`ifdef ARM_IMM_ENC_INV_EN
            if (!pass_q) begin
              // Plain form exhausted: restart the search on ~value.
              work_q <= ~val_q;
              r_q    <= 4'd0;
              pass_q <= 1'b1;
            end else begin
              valid_q <= 1'b0;
              so_q    <= 12'h000;
              inv_q   <= 1'b0;
              state_q <= DONE;
            end
`else
            valid_q <= 1'b0;
            so_q    <= 12'h000;
            inv_q   <= 1'b0;
            state_q <= DONE;
`endif
          end else begin
            work_q <= work_rot_d;
            r_q    <= r_q + 4'd1;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign valid         = valid_q;
  assign shift_operand = so_q;
  assign inv           = inv_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_arm_imm_encoder.sv
// Testbench for arm_imm_encoder: a table of directed constants with
// hand-computed encodings and latencies, plus hand-written sequences for the
// ignored re-start, mid-search reset and back-to-back requests.
module tb_arm_imm_encoder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        valid;
  logic [11:0] shift_operand;
  logic        inv;
  logic [1:0]  dbg_state_o;

  int total = 0;
  int bad   = 0;

  arm_imm_encoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .value         (value),
    .busy          (busy),
    .done          (done),
    .valid         (valid),
    .shift_operand (shift_operand),
    .inv           (inv),
    .dbg_state_o   (dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v;
    int          lat;
    logic        valid;
    logic [11:0] so;
    logic        inv;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one request. start is sampled at edge E0; n counts edges after E0.
  // pulse_at: edge at which a stray start (value 0xFF) is presented, -1 none.
  // rst_at: edge before which rst_n is pulled low, -1 none.
  task automatic run_req(input logic [31:0] v, input int pulse_at, input int rst_at,
                         output int lat, output int busy_cycles);
    int n;
    @(negedge clk);
    start = 1'b1;
    value = v;
    @(posedge clk);
    #1;
    n = 0;
    busy_cycles = busy ? 1 : 0;
    while (!done && n < 60) begin
      @(negedge clk);
      start = (n + 1 == pulse_at);
      value = start ? 32'h0000_00FF : $urandom;
      if (n + 1 == rst_at) rst_n = 1'b0;
      @(posedge clk);
      #1;
      n++;
      if (!rst_n) break;
      if (busy) busy_cycles++;
    end
    @(negedge clk);
    start = 1'b0;
    lat = done ? n : -1;
  endtask

  initial begin
    int lat;
    int bc;
    int done_seen;

    start = 1'b0;
    value = 32'h0;
    rst_n = 1'b0;

    // table: value, done edge, valid, shift_operand, inv
    vecs.push_back('{32'h0000_00FF,  2, 1'b1, 12'h0FF, 1'b0});
    vecs.push_back('{32'hFF00_0000,  6, 1'b1, 12'h4FF, 1'b0});
    vecs.push_back('{32'hF000_000F,  4, 1'b1, 12'h2FF, 1'b0});
    vecs.push_back('{32'h0000_03FC, 17, 1'b1, 12'hFFF, 1'b0});
    vecs.push_back('{32'h8000_0001,  3, 1'b1, 12'h106, 1'b0});
    vecs.push_back('{32'h0000_0000,  2, 1'b1, 12'h000, 1'b0});
`ifdef ARM_IMM_ENC_INV_EN
    vecs.push_back('{32'h0000_0101, 33, 1'b0, 12'h000, 1'b0});
    vecs.push_back('{32'hFFFF_FF00, 18, 1'b1, 12'h0FF, 1'b1});
`else
    vecs.push_back('{32'h0000_0101, 17, 1'b0, 12'h000, 1'b0});
    vecs.push_back('{32'hFFFF_FF00, 17, 1'b0, 12'h000, 1'b0});
`endif
    vecs.push_back('{32'h0000_00AB,  2, 1'b1, 12'h0AB, 1'b0});

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",  busy,          0);
    chk("reset_done",  done,          0);
    chk("reset_valid", valid,         0);
    chk("reset_so",    shift_operand, 0);
    chk("reset_inv",   inv,           0);
    chk("reset_state", dbg_state_o,   0);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven vectors, issued back to back
    foreach (vecs[i]) begin
      run_req(vecs[i].v, -1, -1, lat, bc);
      chk($sformatf("lat[%0d]", i),   lat,              vecs[i].lat);
      chk($sformatf("valid[%0d]", i), valid,            vecs[i].valid);
      chk($sformatf("so[%0d]", i),    shift_operand,    vecs[i].so);
      chk($sformatf("inv[%0d]", i),   inv,              vecs[i].inv);
      chk($sformatf("busy_cyc[%0d]", i), bc,            vecs[i].lat);
      chk($sformatf("busy_end[%0d]", i), busy,          0);
    end

    // done is one cycle wide and results hold while idle
    @(posedge clk);
    #1;
    chk("done_width", done, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_so",    shift_operand, 12'h0AB);
    chk("hold_valid", valid,         1);

    // stray start during search is ignored
    run_req(32'h0000_0101, 3, -1, lat, bc);
`ifdef ARM_IMM_ENC_INV_EN
    chk("ign_lat", lat, 33);
`else
    chk("ign_lat", lat, 17);
`endif
    chk("ign_valid", valid,         0);
    chk("ign_so",    shift_operand, 0);

    // back-to-back: start in the cycle right after done is accepted
    run_req(32'h0000_00FF, -1, -1, lat, bc);
    chk("b2b_first_lat", lat, 2);
    // run_req released start at the negedge after done; re-raise it there
    start = 1'b1;
    value = 32'hFF00_0000;
    @(posedge clk);
    #1;
    chk("b2b_accept_busy", busy, 1);
    chk("b2b_done_low",    done, 0);
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int n = 1; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    chk("b2b_lat", lat, 6);
    chk("b2b_so",  shift_operand, 12'h4FF);

    // reset in the middle of a search aborts to reset values
    run_req(32'h0000_0101, -1, 5, lat, bc);
    chk("rst_lat",   lat,           -1);
    chk("rst_busy",  busy,          0);
    chk("rst_valid", valid,         0);
    chk("rst_so",    shift_operand, 0);
    chk("rst_inv",   inv,           0);
    chk("rst_state", dbg_state_o,   0);
    done_seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    chk("rst_no_done", done_seen, 0);

    // recovers normally after reset
    run_req(32'h0000_0FF0, -1, -1, lat, bc);
    chk("post_rst_lat", lat, 16);
    chk("post_rst_so",  shift_operand, 12'hEFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
